video_timing_lock: RTL and testbench
====================================

// Module: video_timing_lock
// PURPOSE
//  Sits between the HDMI input interface and the image-processing pipeline.
//  Measures incoming DE/HS/VS timing, locks onto the expected active format and
//  generates pixel coordinates plus frame/line markers for downstream filters.
//  Gates pipeline validity until the format is stable, and drops lock on any mismatch.
// PARAMETERS
//  H_ACT        64  expected active pixels per line
//  V_ACT        64  expected active lines per frame
//  CW           11  width of x/y/measurement counters
//  LOCK_FRAMES  2   consecutive good frames required to assert lock (>=1)
// PORTS
//  clk        in   1   pixel clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  en         in   1   block enable; 0 forces IDLE
//  de_in      in   1   data enable, active high
//  hs_in      in   1   hsync, active-high pulse
//  vs_in      in   1   vsync, active-high pulse
//  r_in/g_in/b_in in 8 each  pixel data
//  de_out, hs_out, vs_out  out 1   registered copies of inputs
//  r_out/g_out/b_out       out 8   registered copies of pixel data
//  valid      out  1   de_out & locked
//  x, y       out  CW  coordinates of pixel on r/g/b_out; valid when de_out=1
//  sof        out  1   1-cycle pulse: valid && x==0 && y==0
//  eol        out  1   1-cycle pulse: valid && x==H_ACT-1
//  locked     out  1   format locked
//  fmt_err    out  1   1-cycle pulse on a frame that failed the format check
//  width_meas, height_meas  out CW  last frame's measured line width / line count
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, all counters and good-frame count 0.
//  - Datapath latency: exactly 1 clk, input to *_out; x/y/sof/eol/valid are aligned with de_out.
//  - x: 0 on the first DE cycle of a line, +1 per DE cycle, cleared when DE falls.
//    y: +1 on each DE falling edge, cleared on VS rising edge.
//    Both counters saturate at 2^CW-1. Saturation counts as a mismatch.
//  - vs_rise = vs_in & ~vs_in_d. Frame check evaluated at each vs_rise:
//    good = (every line width == H_ACT) && (line count == V_ACT) && no saturation.
//    Latch width_meas/height_meas at vs_rise (width = width of last line).
//  - FSM states:
//    IDLE:    en=1 -> WAIT_VS.
//    WAIT_VS: first vs_rise -> MEASURE. The partial frame is not checked.
//    MEASURE: at vs_rise: good -> good_cnt+1; bad -> good_cnt=0 and fmt_err=1.
//             When good_cnt reaches LOCK_FRAMES -> LOCKED, locked=1 on the next cycle.
//    LOCKED:  at vs_rise: bad -> fmt_err=1, locked=0, good_cnt=0, MEASURE.
//  - From any state, en=0 -> IDLE on the next cycle: locked=0, good_cnt=0.
//    Passthrough of *_out continues.
//  - vs_rise while de_in=1 -> the frame is bad.
//  - vs_rise and DE falling in the same cycle: count the line first, then evaluate.
//  - Reset mid-frame: return to IDLE. Lock is reacquired only via WAIT_VS and a full measure.
// TESTING
//  1 Source 64x64, 83 clk/line, 84 lines/frame, en=1
//    -> locked=1 exactly 1 clk after the 3rd vs_rise (WAIT_VS + 2 good frames);
//       width_meas=64, height_meas=64.
//  2 Locked stream -> per frame exactly one sof at (0,0) and 64 eol pulses;
//    x runs 0..63; valid count per frame = 4096.
//  3 One line of 63 pixels in a locked frame -> fmt_err pulse at the next vs_rise,
//    locked=0, re-lock after 2 further good frames.
//  4 Source 65 lines/frame -> height_meas=65, fmt_err on every frame, locked never asserts.
//  5 rst=1 for 1 clk mid-frame while locked -> all outputs 0 on the next clk;
//    locked reasserts after WAIT_VS + 2 frames.
//  6 Drop en for 10 clk while locked -> locked=0 within 1 clk;
//    *_out still mirrors the inputs with 1-clk latency.

Source files
------------

// File: rtl/video_timing_lock.sv
// Input-side video timing monitor: registers DE/HS/VS/RGB, derives pixel coordinates,
// measures each frame against the expected active format and gates validity until locked.
module video_timing_lock #(
    parameter int H_ACT       = 64,
    parameter int V_ACT       = 64,
    parameter int CW          = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          de_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic [7:0]    r_in,
    input  logic [7:0]    g_in,
    input  logic [7:0]    b_in,
    output logic          de_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic [7:0]    r_out,
    output logic [7:0]    g_out,
    output logic [7:0]    b_out,
    output logic          valid,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          locked,
    output logic          fmt_err,
    output logic [CW-1:0] width_meas,
    output logic [CW-1:0] height_meas
);

    localparam logic [CW-1:0] C_MAX  = '1;
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] H_EXP  = CW'(H_ACT);
    localparam logic [CW-1:0] V_EXP  = CW'(V_ACT);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACT - 1);
    localparam int            GW     = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] G_LOCK = GW'(LOCK_FRAMES);
    localparam logic [GW-1:0] G_ONE  = {{(GW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_MEASURE,
        S_LOCKED
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == C_MAX) ? v : v + C_ONE;
    endfunction

    logic          r_de_p1, r_hs_p1, r_vs_p1;
    logic [7:0]    r_r_p1, r_g_p1, r_b_p1;
    logic [CW-1:0] r_x, r_y, r_last_w, r_width_meas, r_height_meas;
    logic          r_bad_w, r_sat, r_fmt_err;
    logic [GW-1:0] r_good_cnt;
    state_t        r_state;

    logic          w_vs_rise, w_de_fall, w_x_sat, w_y_sat, w_bad_w_now, w_good;
    logic [CW-1:0] w_cur_w, w_lines;
    logic [GW-1:0] w_good_inc, w_good_nxt;
    state_t        w_state_nxt;
    logic          w_fmt_err_nxt;

    // Edge detection against the registered copies; a line ending in the same cycle
    // as a VS edge is folded into the count before the frame is judged.
    assign w_vs_rise   = vs_in & ~r_vs_p1;
    assign w_de_fall   = ~de_in & r_de_p1;
    assign w_cur_w     = sat_inc(r_x);
    assign w_x_sat     = de_in & r_de_p1 & (r_x == C_MAX);
    assign w_y_sat     = w_de_fall & (r_y == C_MAX);
    assign w_lines     = w_de_fall ? sat_inc(r_y) : r_y;
    assign w_bad_w_now = w_de_fall & (w_cur_w != H_EXP);
    assign w_good      = ~r_bad_w & ~w_bad_w_now & ~r_sat & ~w_x_sat & ~w_y_sat
                         & (w_lines == V_EXP) & ~de_in;

    // Stage p1: passthrough, coordinates and per-frame measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_de_p1       <= 1'b0;
            r_hs_p1       <= 1'b0;
            r_vs_p1       <= 1'b0;
            r_r_p1        <= '0;
            r_g_p1        <= '0;
            r_b_p1        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_last_w      <= '0;
            r_width_meas  <= '0;
            r_height_meas <= '0;
            r_bad_w       <= 1'b0;
            r_sat         <= 1'b0;
        end else begin
            r_de_p1 <= de_in;
            r_hs_p1 <= hs_in;
            r_vs_p1 <= vs_in;
            r_r_p1  <= r_in;
            r_g_p1  <= g_in;
            r_b_p1  <= b_in;
            r_x     <= (de_in && r_de_p1) ? sat_inc(r_x) : '0;

            if (w_vs_rise) begin
                r_y <= '0;
            end else if (w_de_fall) begin
                r_y <= sat_inc(r_y);
            end

            if (w_de_fall) begin
                r_last_w <= w_cur_w;
            end

            if (w_vs_rise) begin
                r_bad_w       <= 1'b0;
                r_sat         <= 1'b0;
                r_width_meas  <= w_de_fall ? w_cur_w : r_last_w;
                r_height_meas <= w_lines;
            end else begin
                if (w_bad_w_now) begin
                    r_bad_w <= 1'b1;
                end
                if (w_x_sat || w_y_sat) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign w_good_inc = r_good_cnt + G_ONE;

    always_comb begin
        w_state_nxt   = r_state;
        w_good_nxt    = r_good_cnt;
        w_fmt_err_nxt = 1'b0;
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_good_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_VS;
                    w_good_nxt  = '0;
                end
                S_WAIT_VS: begin
                    if (w_vs_rise) begin
                        w_state_nxt = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_vs_rise) begin
                        if (w_good) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == G_LOCK) begin
                                w_state_nxt = S_LOCKED;
                            end
                        end else begin
                            w_good_nxt    = '0;
                            w_fmt_err_nxt = 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_vs_rise && !w_good) begin
                        w_state_nxt   = S_MEASURE;
                        w_good_nxt    = '0;
                        w_fmt_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

    // Stage p1: lock control, updated on the same edge as the datapath copies
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_good_cnt <= '0;
            r_fmt_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_fmt_err  <= w_fmt_err_nxt;
        end
    end

    assign de_out      = r_de_p1;
    assign hs_out      = r_hs_p1;
    assign vs_out      = r_vs_p1;
    assign r_out       = r_r_p1;
    assign g_out       = r_g_p1;
    assign b_out       = r_b_p1;
    assign x           = r_x;
    assign y           = r_y;
    assign locked      = (r_state == S_LOCKED);
    assign valid       = r_de_p1 & locked;
    assign sof         = valid & (r_x == '0) & (r_y == '0);
    assign eol         = valid & (r_x == H_LAST);
    assign fmt_err     = r_fmt_err;
    assign width_meas  = r_width_meas;
    assign height_meas = r_height_meas;

endmodule

// File: tb/tb_video_timing_lock.sv
// Directed bench for video_timing_lock: 83 clk/line, 84 lines/frame source with a
// one-deep scoreboard of expected outputs for every driven cycle.
module tb_video_timing_lock;

    localparam int H   = 64;
    localparam int V   = 64;
    localparam int CW  = 11;
    localparam int LPL = 83;

    logic          clk = 1'b0;
    logic          rst, en, de_in, hs_in, vs_in;
    logic [7:0]    r_in, g_in, b_in;
    logic          de_out, hs_out, vs_out, valid, sof, eol, locked, fmt_err;
    logic [7:0]    r_out, g_out, b_out;
    logic [CW-1:0] x, y, width_meas, height_meas;

    always #5 clk = ~clk;

    video_timing_lock #(.H_ACT(H), .V_ACT(V), .CW(CW), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .valid(valid), .x(x), .y(y), .sof(sof), .eol(eol), .locked(locked),
        .fmt_err(fmt_err), .width_meas(width_meas), .height_meas(height_meas)
    );

    typedef struct {
        logic        zero;
        logic [26:0] pass;
        logic        de;
        int          xx;
        int          yy;
        logic        lk;
        logic        er;
        logic        cchk;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vcnt, scnt, ecnt;
    logic exp_locked = 1'b0;
    logic coord_ok   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic irst, input logic ien, input logic ide, input logic ihs,
                       input logic ivs, input int xx, input int yy, input logic er);
        exp_t        e;
        exp_t        o;
        logic [31:0] rnd;
        rnd   = $urandom;
        rst   = irst;
        en    = ien;
        de_in = ide;
        hs_in = ihs;
        vs_in = ivs;
        r_in  = rnd[7:0];
        g_in  = rnd[15:8];
        b_in  = rnd[23:16];
        e.zero = irst;
        e.pass = {ide, ihs, ivs, rnd[7:0], rnd[15:8], rnd[23:16]};
        e.de   = ide;
        e.xx   = xx;
        e.yy   = yy;
        e.lk   = exp_locked;
        e.er   = er;
        e.cchk = coord_ok;
        q.push_back(e);
        @(posedge clk);
        #1;
        o = q.pop_front();
        if (o.zero) begin
            chk("rst_flags", 32'({de_out, hs_out, vs_out, valid, sof, eol, locked, fmt_err}), 32'd0);
            chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
            chk("rst_xy", 32'({x, y}), 32'd0);
            chk("rst_meas", 32'({width_meas, height_meas}), 32'd0);
        end else begin
            chk("passthru", 32'({de_out, hs_out, vs_out, r_out, g_out, b_out}), 32'(o.pass));
            chk("locked", 32'(locked), 32'(o.lk));
            chk("valid", 32'(valid), 32'(o.de & o.lk));
            chk("fmt_err", 32'(fmt_err), 32'(o.er));
            chk("sof", 32'(sof), 32'(o.de && o.lk && o.xx == 0 && o.yy == 0));
            chk("eol", 32'(eol), 32'(o.de && o.lk && o.xx == H - 1));
            if (o.de && o.cchk) begin
                chk("x", 32'(x), 32'(o.xx));
                chk("y", 32'(y), 32'(o.yy));
            end
        end
        if (valid) vcnt++;
        if (sof) scnt++;
        if (eol) ecnt++;
    endtask

    // Lines l0..l1 of one frame; VS is high on lines 70..72, so its rising edge is line 70 cycle 0.
    // lk_v/er_v: expected locked and fmt_err right after that edge; ew<0 skips the measurement check.
    task automatic frame(input int l0, input int l1, input int act, input int short_ln,
                         input logic lk_v, input logic er_v, input int ew, input int eh,
                         input int rst_ln, input int enoff_ln);
        for (int ln = l0; ln <= l1; ln++) begin
            for (int c = 0; c < LPL; c++) begin
                int   w;
                logic de, hs, vs, vsr, irst, ien, er;
                w    = (ln == short_ln) ? H - 1 : H;
                de   = (ln < act) && (c < w);
                hs   = (c >= 70) && (c < 76);
                vs   = (ln >= 70) && (ln < 73);
                vsr  = (ln == 70) && (c == 0);
                irst = (ln == rst_ln) && (c == 10);
                ien  = !((ln == enoff_ln) && (c >= 20) && (c < 30));
                er   = 1'b0;
                if (vsr) begin
                    exp_locked = lk_v;
                    er         = er_v;
                    coord_ok   = 1'b1;
                end
                if (irst || !ien) exp_locked = 1'b0;
                cyc(irst, ien, de, hs, vs, c, ln, er);
                if (irst) coord_ok = 1'b0;
                if (vsr && ew >= 0) begin
                    chk("width_meas", 32'(width_meas), 32'(ew));
                    chk("height_meas", 32'(height_meas), 32'(eh));
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vcnt = 0;
        scnt = 0;
        ecnt = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Acquire: first VS edge leaves WAIT_VS, two good frames then lock
        frame(64, 83, 64, -1, 1'b0, 1'b0, 0, 0, -1, -1);
        frame(0, 83, 64, -1, 1'b0, 1'b0, 64, 64, -1, -1);
        frame(0, 83, 64, -1, 1'b1, 1'b0, 64, 64, -1, -1);

        // One complete locked frame: marker and valid counts
        vcnt = 0;
        scnt = 0;
        ecnt = 0;
        frame(0, 83, 64, -1, 1'b1, 1'b0, 64, 64, -1, -1);
        chk("valid_cnt", 32'(vcnt), 32'd4096);
        chk("sof_cnt", 32'(scnt), 32'd1);
        chk("eol_cnt", 32'(ecnt), 32'd64);

        // Short line drops lock, then two good frames re-lock
        frame(0, 83, 64, 10, 1'b0, 1'b1, 64, 64, -1, -1);
        frame(0, 83, 64, -1, 1'b0, 1'b0, 64, 64, -1, -1);
        frame(0, 83, 64, -1, 1'b1, 1'b0, 64, 64, -1, -1);

        // Reset pulse mid-line while locked, then WAIT_VS plus two frames
        frame(0, 83, 64, -1, 1'b0, 1'b0, -1, -1, 5, -1);
        frame(0, 83, 64, -1, 1'b0, 1'b0, 64, 64, -1, -1);
        frame(0, 83, 64, -1, 1'b1, 1'b0, 64, 64, -1, -1);

        // Enable dropped for 10 clk while locked; source then switches to 65 lines
        frame(0, 83, 65, -1, 1'b0, 1'b0, 64, 65, -1, 5);
        frame(0, 71, 65, -1, 1'b0, 1'b1, 64, 65, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
